// File: rtl/hex_display_pkg.sv
// hex_display_pkg
// Shared constants and types for the hex display blocks: digit count,
// blank segment pattern, the 7-segment vector type and the active-low
// nibble-to-segment table. Segment bit order is {g,f,e,d,c,b,a}.
package hex_display_pkg;

    localparam int NUM_DIGITS = 8;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK = 7'h7F;

    // Active-low segment codes, indexed by nibble value 0..F.
    localparam seg7_t SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/hex_display_driver_hex_to_seg7.sv
// hex_to_seg7
// Combinational nibble to active-low 7-segment decoder.
// Ports:
//   nibble_i : 4-bit hex value
//   seg_o    : segments {g,f,e,d,c,b,a}, active-low
module hex_to_seg7
    import hex_display_pkg::*;
(
    input  logic [3:0] nibble_i,
    output seg7_t      seg_o
);

    assign seg_o = SEG_TABLE[nibble_i];

endmodule

// File: rtl/hex_display_driver.sv
// hex_display_driver
// Shows a captured 32-bit value as 8 hex digits on a multiplexed,
// common-anode 7-segment display, with optional leading-zero blanking.
// Ports:
//   CLK    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   data_i : value to display
//   load_i : capture strobe, data_i sampled on the edge where it is 1
//   en_i   : display enable, 0 turns all anodes off
//   AN     : digit anodes, active-low, AN[i] shows nibble i
//   SEG    : segments {g,f,e,d,c,b,a}, active-low
//   DP     : decimal point, active-low, held off
module hex_display_driver
    import hex_display_pkg::*;
#(
    parameter int REFRESH_DIV   = 50000,
    parameter int BLANK_LEADING = 1
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic [31:0] data_i,
    input  logic        load_i,
    input  logic        en_i,
    output logic [7:0]  AN,
    output logic [6:0]  SEG,
    output logic        DP
);

    localparam int PRESC_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_TC = PRESC_W'(REFRESH_DIV - 1);

    logic [31:0]        data_d,  data_q;
    logic [PRESC_W-1:0] presc_d, presc_q;
    logic [2:0]         digit_d, digit_q;
    logic [7:0]         an_d,    an_q;
    seg7_t              seg_d,   seg_q;
    logic               dp_d,    dp_q;

    logic [NUM_DIGITS-1:0] blank;
    logic [3:0]            nibble;
    seg7_t                 seg_dec;

    assign nibble = data_q[{digit_q, 2'b00} +: 4];

    hex_to_seg7 u_dec (
        .nibble_i (nibble),
        .seg_o    (seg_dec)
    );

    // Digit i is a leading zero when every nibble from i upward is zero.
    // Digit 0 is never blanked so a zero value still shows one "0".
    always_comb begin
        blank = '0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            blank[i] = (BLANK_LEADING != 0) && ((data_q >> (4 * i)) == 32'd0);
        end
    end

    always_comb begin
        data_d  = load_i ? data_i : data_q;
        presc_d = presc_q + 1'b1;
        digit_d = digit_q;
        if (presc_q == PRESC_TC) begin
            presc_d = '0;
            digit_d = digit_q + 3'd1;
        end

        an_d  = 8'hFF;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (en_i && !blank[digit_q]) begin
            an_d  = ~(8'b1 << digit_q);
            seg_d = seg_dec;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            presc_q <= '0;
            digit_q <= '0;
            an_q    <= 8'hFF;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b1;
        end else begin
            data_q  <= data_d;
            presc_q <= presc_d;
            digit_q <= digit_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign AN  = an_q;
    assign SEG = seg_q;
    assign DP  = dp_q;

endmodule

// File: tb/tb_hex_display_driver.sv
module tb_hex_display_driver;

    localparam int DIV = 4;

    logic        CLK = 1'b0;
    logic        rst_n;
    logic [31:0] data_i;
    logic        load_i;
    logic        en_i;

    logic [7:0] an_full, an_blank;
    logic [6:0] seg_full, seg_blank;
    logic       dp_full, dp_blank;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    hex_display_driver #(.REFRESH_DIV(DIV), .BLANK_LEADING(0)) u_dut_full (
        .CLK(CLK), .rst_n(rst_n), .data_i(data_i), .load_i(load_i), .en_i(en_i),
        .AN(an_full), .SEG(seg_full), .DP(dp_full)
    );

    hex_display_driver #(.REFRESH_DIV(DIV), .BLANK_LEADING(1)) u_dut_blank (
        .CLK(CLK), .rst_n(rst_n), .data_i(data_i), .load_i(load_i), .en_i(en_i),
        .AN(an_blank), .SEG(seg_blank), .DP(dp_blank)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: digit position follows from the number of edges since
    // reset; expected outputs come straight from the display rules.
    logic [6:0] seg_tab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    int          m_edges;
    logic [31:0] m_data;
    logic [7:0]  exp_an_full, exp_an_blank;
    logic [6:0]  exp_seg_full, exp_seg_blank;

    function automatic void calc(input bit bl, input logic [31:0] d, input int dig,
                                 input bit en, output logic [7:0] an, output logic [6:0] seg);
        logic [31:0] upper;
        upper = d >> (4 * dig);
        if (!en || (bl && dig > 0 && upper == 0)) begin
            an  = 8'hFF;
            seg = 7'h7F;
        end else begin
            an  = 8'hFF ^ (8'd1 << dig);
            seg = seg_tab[upper[3:0]];
        end
    endfunction

    always @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            m_edges       = 0;
            m_data        = 0;
            exp_an_full   = 8'hFF;
            exp_an_blank  = 8'hFF;
            exp_seg_full  = 7'h7F;
            exp_seg_blank = 7'h7F;
        end else begin
            int dig;
            dig = (m_edges / DIV) % 8;
            calc(1'b0, m_data, dig, en_i, exp_an_full, exp_seg_full);
            calc(1'b1, m_data, dig, en_i, exp_an_blank, exp_seg_blank);
            if (load_i) m_data = data_i;
            m_edges++;
        end
    end

    always @(negedge CLK) begin
        check("an_full",  {24'd0, an_full},   {24'd0, exp_an_full});
        check("seg_full", {25'd0, seg_full},  {25'd0, exp_seg_full});
        check("an_blank", {24'd0, an_blank},  {24'd0, exp_an_blank});
        check("seg_blank",{25'd0, seg_blank}, {25'd0, exp_seg_blank});
        check("dp",       {30'd0, dp_full, dp_blank}, 32'd3);
        check("an_onehot_full",  32'($countones(~an_full)  <= 1), 32'd1);
        check("an_onehot_blank", 32'($countones(~an_blank) <= 1), 32'd1);
    end

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge CLK);
    endtask

    task automatic load(input logic [31:0] v);
        data_i = v;
        load_i = 1'b1;
        @(negedge CLK);
        load_i = 1'b0;
    endtask

    task automatic async_reset(input int hold);
        @(negedge CLK);
        #2 rst_n = 1'b0;
        #1;
        check("rst_an",  {24'd0, an_full},  32'hFF);
        check("rst_seg", {25'd0, seg_blank}, 32'h7F);
        check("rst_dp",  {31'd0, dp_full},  32'd1);
        cycles(hold);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        data_i = '0;
        load_i = 1'b0;
        en_i   = 1'b1;
        cycles(3);
        rst_n = 1'b1;
        @(negedge CLK);
        check("first_an",  {24'd0, an_full},  32'hFE);
        check("first_seg", {25'd0, seg_full}, 32'h40);

        // Reset mid-frame with the display enabled.
        cycles(9);
        async_reset(5);
        @(negedge CLK);
        check("rel_an",  {24'd0, an_blank},  32'hFE);
        check("rel_seg", {25'd0, seg_blank}, 32'h40);

        // Full scan, leading-zero pattern, zero value.
        load(32'h0123ABCF);
        cycles(8 * DIV + 6);
        load(32'h000000A5);
        cycles(8 * DIV + 6);
        load(32'h0);
        cycles(8 * DIV + 2);

        // Enable drop mid-frame.
        load(32'h89ABCDEF);
        cycles(7);
        en_i = 1'b0;
        cycles(10);
        en_i = 1'b1;
        cycles(10);

        // Load exactly at the prescaler terminal count.
        load(32'h12345678);
        cycles(5);
        while (m_edges % DIV != DIV - 1) @(negedge CLK);
        load(32'hFFFFFFFF);
        @(negedge CLK);
        check("collide_seg", {25'd0, seg_full},  32'h0E);
        check("collide_blk", {25'd0, seg_blank}, 32'h0E);
        cycles(DIV * 3);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 12) begin
                data_i = $urandom >> $urandom_range(0, 31);
                load_i = 1'b1;
            end else begin
                load_i = 1'b0;
            end
            if ($urandom_range(0, 49) == 0) en_i = ~en_i;
            if (i % 200 == 0 && i > 0) begin
                load_i = 1'b0;
                async_reset($urandom_range(1, 4));
            end else begin
                @(negedge CLK);
            end
        end
        load_i = 1'b0;
        en_i   = 1'b1;
        cycles(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hex_display_driver.md
Name: hex_display_driver

Overview:
- Downstream consumer of the processor core's 32-bit OUT bus; shows the value as 8 hexadecimal digits on a multiplexed, common-anode 7-segment display (board-level output stage).
- Captures the value on a load strobe.
- Time-multiplexes the digits with a programmable prescaler.
- Optional leading-zero blanking.
- All display outputs are registered, so they are glitch-free.

Parameters:
REFRESH_DIV, 50000, clock cycles each digit stays lit; legal range is ≥2 (2 kHz per digit at 100 MHz).
BLANK_LEADING, 1, 1 = suppress leading zero digits (digit 0 is never blanked); 0 = always show all 8.

Ports:
CLK  input  1  system clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
data_i  input  32  value to display (driven from the core's OUT).
load_i  input  1  capture strobe; data_i is sampled on the CLK edge where load_i=1.
en_i  input  1  display enable; 0 turns all anodes off.
AN  output  8  digit anodes, active-low; AN[i] selects nibble data[4i+3:4i].
SEG  output  7  segments {g,f,e,d,c,b,a}, active-low.
DP  output  1  decimal point, active-low; always 1 (off) after reset.

Behaviour:
- Reset (async on rst_n=0, held while low):
  - data_q=0, prescaler=0, digit_idx=0.
  - AN=8'hFF, SEG=7'h7F, DP=1.
  - Reset mid-scan aborts immediately; there is no partial state.
- Capture register:
  - data_q<=data_i on each edge with load_i=1; otherwise data_q holds.
  - load_i held high means data_q tracks data_i every cycle.
- Prescaler:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - At terminal count (REFRESH_DIV-1), digit_idx<=digit_idx+1 mod 8 (7→0).
  - Prescaler and digit_idx always run, independent of en_i.
- Output register (updated every edge):
  - Computed from the current digit_idx, data_q and en_i; latency is 1 cycle from any of these.
  - Normal case: AN<=~(8'b1<<digit_idx), SEG<=seg7(data_q nibble digit_idx).
  - Blanked digit: AN<=8'hFF and SEG<=7'h7F.
  - en_i=0: AN<=8'hFF and SEG<=7'h7F.
  - DP<=1 always.
- Blanking rule: digit i (i≥1) is blank when BLANK_LEADING=1 and data_q[31:4i]==0. Digit 0 is never blanked, so a value of 0 shows a single "0".
- Segment code (active-low, {g..a}):
  - 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78
  - 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex)
- Timing:
  - After rst_n deasserts, the first edge drives AN=FE with digit 0.
  - Each digit is lit for exactly REFRESH_DIV cycles; a full frame is 8·REFRESH_DIV cycles.
- Simultaneous events:
  - load_i at the terminal count: the new digit_idx and the new data_q take effect together on the following edge.
  - No mixed old/new frame artefact is required beyond 1 cycle.
- Exactly one AN bit is low at any time, or none. Two low bits is a bug.

Decomposition:
- Package hex_display_pkg:
  - NUM_DIGITS=8.
  - SEG_BLANK=7'h7F.
  - 16-entry segment constant table.
  - Typedef for the 7-bit segment vector.
- Sub-module hex_to_seg7: combinational nibble→active-low 7-segment decoder, reusable by other display blocks.
- Top contains: prescaler, digit counter, capture register, blanking logic, output registers.

Test Plan:
1. Reset/hold: rst_n=0 for 5 cycles, mid-frame, with en_i=1 → AN=FF, SEG=7F, DP=1 throughout, asynchronously on the falling rst_n. After release, the first edge gives AN=FE, SEG=40.
2. Full scan: REFRESH_DIV=4, BLANK_LEADING=0, load 0x0123ABCF → digits 0..7 show 0E,46,03,08,30,24,79,40. Each digit shows for exactly 4 cycles with AN=FE,FD,…,7F, then wraps to FE.
3. Blanking: BLANK_LEADING=1, load 0x000000A5 → only AN=FE (SEG=12) and AN=FD (SEG=08) ever assert. During digits 2..7, AN=FF. Load 0 → only digit 0 shown, SEG=40.
4. Enable: en_i=0 for 10 cycles mid-frame → AN=FF one cycle after the drop. Re-enable → the digit matching the still-advancing digit_idx appears one cycle later.
5. Load collision: pulse load_i with 0xFFFFFFFF exactly at the prescaler terminal count → next edge shows the next digit with SEG=0E. The old value never appears on that digit.
6. Invariant monitor (all tests): $countones(~AN)≤1 every cycle; DP==1 always.
